// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sram_arbiter
//  Purpose  : Round-robin arbiter for the CPU instruction and data ports,
//             serving two single-port RAMs through a multi-cycle access FSM.
//  Revision : 1.0  initial release
// ============================================================================
module sram_arbiter #(
    parameter int RAM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        is_if_read,

    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        is_mem_read,

    output logic        base_ram_en,
    output logic [3:0]  base_ram_we,
    output logic [19:0] base_ram_addr,
    output logic [31:0] base_ram_wdata,
    input  logic [31:0] base_ram_rdata,

    output logic        ext_ram_en,
    output logic [3:0]  ext_ram_we,
    output logic [19:0] ext_ram_addr,
    output logic [31:0] ext_ram_wdata,
    input  logic [31:0] ext_ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [1:0] c_tgt_none = 2'd0;
    localparam logic [1:0] c_tgt_base = 2'd1;
    localparam logic [1:0] c_tgt_ext  = 2'd2;
    localparam logic [2:0] c_cnt_init = 3'(RAM_LAT - 1);

    state_t      r_state;
    state_t      w_state_next;
    logic [2:0]  r_cnt;
    logic        r_last_data;
    logic        r_port_data;
    logic [1:0]  r_tgt;
    logic        r_is_write;

    logic        w_req_any;
    logic        w_gnt_data;
    logic        w_grant;
    logic        w_last;
    logic [31:0] w_addr;
    logic [3:0]  w_we;
    logic [31:0] w_wdata;
    logic [1:0]  w_tgt;
    logic [31:0] w_rd_word;
    logic        w_unused;

    assign w_unused = ^{inst_sram_addr[1:0], data_sram_addr[1:0]};

    // Data wins a tie unless it was the last port served.
    assign w_req_any  = inst_sram_en | data_sram_en;
    assign w_gnt_data = data_sram_en & (~inst_sram_en | ~r_last_data);
    assign w_grant    = (r_state == S_IDLE) && w_req_any;
    assign w_last     = (r_state == S_ACCESS) && (r_cnt == 3'd0);

    assign w_addr  = w_gnt_data ? data_sram_addr  : inst_sram_addr;
    assign w_we    = w_gnt_data ? data_sram_we    : inst_sram_we;
    assign w_wdata = w_gnt_data ? data_sram_wdata : inst_sram_wdata;

    always_comb begin
        w_tgt = c_tgt_none;
        if (w_addr[31:22] == 10'h200) begin
            w_tgt = c_tgt_base;
        end else if (w_addr[31:22] == 10'h201) begin
            w_tgt = c_tgt_ext;
        end
    end

    always_comb begin
        w_rd_word = 32'h0;
        if (r_tgt == c_tgt_base) begin
            w_rd_word = base_ram_rdata;
        end else if (r_tgt == c_tgt_ext) begin
            w_rd_word = ext_ram_rdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (w_req_any) w_state_next = S_ACCESS;
            S_ACCESS: if (r_cnt == 3'd0) w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // The RAM output registers double as the latched address/strobe/data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt           <= 3'd0;
            r_last_data     <= 1'b0;
            r_port_data     <= 1'b0;
            r_tgt           <= c_tgt_none;
            r_is_write      <= 1'b0;
            base_ram_en     <= 1'b0;
            base_ram_we     <= 4'h0;
            base_ram_addr   <= 20'h0;
            base_ram_wdata  <= 32'h0;
            ext_ram_en      <= 1'b0;
            ext_ram_we      <= 4'h0;
            ext_ram_addr    <= 20'h0;
            ext_ram_wdata   <= 32'h0;
            inst_sram_rdata <= 32'h0;
            data_sram_rdata <= 32'h0;
            is_if_read      <= 1'b0;
            is_mem_read     <= 1'b0;
        end else begin
            is_if_read  <= 1'b0;
            is_mem_read <= 1'b0;
            if (w_grant) begin
                r_cnt          <= c_cnt_init;
                r_last_data    <= w_gnt_data;
                r_port_data    <= w_gnt_data;
                r_tgt          <= w_tgt;
                r_is_write     <= (w_we != 4'h0);
                base_ram_en    <= (w_tgt == c_tgt_base);
                base_ram_we    <= (w_tgt == c_tgt_base) ? w_we : 4'h0;
                base_ram_addr  <= (w_tgt == c_tgt_base) ? w_addr[21:2] : 20'h0;
                base_ram_wdata <= (w_tgt == c_tgt_base) ? w_wdata : 32'h0;
                ext_ram_en     <= (w_tgt == c_tgt_ext);
                ext_ram_we     <= (w_tgt == c_tgt_ext) ? w_we : 4'h0;
                ext_ram_addr   <= (w_tgt == c_tgt_ext) ? w_addr[21:2] : 20'h0;
                ext_ram_wdata  <= (w_tgt == c_tgt_ext) ? w_wdata : 32'h0;
            end else if (w_last) begin
                base_ram_en    <= 1'b0;
                base_ram_we    <= 4'h0;
                base_ram_addr  <= 20'h0;
                base_ram_wdata <= 32'h0;
                ext_ram_en     <= 1'b0;
                ext_ram_we     <= 4'h0;
                ext_ram_addr   <= 20'h0;
                ext_ram_wdata  <= 32'h0;
                if (!r_is_write) begin
                    if (r_port_data) begin
                        data_sram_rdata <= w_rd_word;
                    end else begin
                        inst_sram_rdata <= w_rd_word;
                    end
                end
                is_mem_read <= r_port_data;
                is_if_read  <= ~r_port_data;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_arbiter
//  Purpose  : Directed self-checking bench for sram_arbiter (RAM_LAT 2, 1, 4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk;
    logic        reset;
    logic        inst_en, data_en;
    logic [3:0]  inst_we, data_we;
    logic [31:0] inst_addr, data_addr, inst_wdata, data_wdata;
    logic [31:0] base_rd, ext_rd;

    logic [31:0] inst_rdata, data_rdata;
    logic        if_done, mem_done;
    logic        base_en, ext_en;
    logic [3:0]  base_we, ext_we;
    logic [19:0] base_addr, ext_addr;
    logic [31:0] base_wdata, ext_wdata;

    logic [31:0] l1_inst_rdata, l1_data_rdata;
    logic        l1_if_done, l1_mem_done, l1_base_en, l1_ext_en;
    logic [3:0]  l1_base_we, l1_ext_we;
    logic [19:0] l1_base_addr, l1_ext_addr;
    logic [31:0] l1_base_wdata, l1_ext_wdata;

    logic [31:0] l4_inst_rdata, l4_data_rdata;
    logic        l4_if_done, l4_mem_done, l4_base_en, l4_ext_en;
    logic [3:0]  l4_base_we, l4_ext_we;
    logic [19:0] l4_base_addr, l4_ext_addr;
    logic [31:0] l4_base_wdata, l4_ext_wdata;

    int checks   = 0;
    int failures = 0;

    sram_arbiter #(.RAM_LAT(2)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_en), .inst_sram_we(inst_we), .inst_sram_addr(inst_addr),
        .inst_sram_wdata(inst_wdata), .inst_sram_rdata(inst_rdata), .is_if_read(if_done),
        .data_sram_en(data_en), .data_sram_we(data_we), .data_sram_addr(data_addr),
        .data_sram_wdata(data_wdata), .data_sram_rdata(data_rdata), .is_mem_read(mem_done),
        .base_ram_en(base_en), .base_ram_we(base_we), .base_ram_addr(base_addr),
        .base_ram_wdata(base_wdata), .base_ram_rdata(base_rd),
        .ext_ram_en(ext_en), .ext_ram_we(ext_we), .ext_ram_addr(ext_addr),
        .ext_ram_wdata(ext_wdata), .ext_ram_rdata(ext_rd)
    );

    sram_arbiter #(.RAM_LAT(1)) dut_l1 (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_en), .inst_sram_we(inst_we), .inst_sram_addr(inst_addr),
        .inst_sram_wdata(inst_wdata), .inst_sram_rdata(l1_inst_rdata), .is_if_read(l1_if_done),
        .data_sram_en(data_en), .data_sram_we(data_we), .data_sram_addr(data_addr),
        .data_sram_wdata(data_wdata), .data_sram_rdata(l1_data_rdata), .is_mem_read(l1_mem_done),
        .base_ram_en(l1_base_en), .base_ram_we(l1_base_we), .base_ram_addr(l1_base_addr),
        .base_ram_wdata(l1_base_wdata), .base_ram_rdata(base_rd),
        .ext_ram_en(l1_ext_en), .ext_ram_we(l1_ext_we), .ext_ram_addr(l1_ext_addr),
        .ext_ram_wdata(l1_ext_wdata), .ext_ram_rdata(ext_rd)
    );

    sram_arbiter #(.RAM_LAT(4)) dut_l4 (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_en), .inst_sram_we(inst_we), .inst_sram_addr(inst_addr),
        .inst_sram_wdata(inst_wdata), .inst_sram_rdata(l4_inst_rdata), .is_if_read(l4_if_done),
        .data_sram_en(data_en), .data_sram_we(data_we), .data_sram_addr(data_addr),
        .data_sram_wdata(data_wdata), .data_sram_rdata(l4_data_rdata), .is_mem_read(l4_mem_done),
        .base_ram_en(l4_base_en), .base_ram_we(l4_base_we), .base_ram_addr(l4_base_addr),
        .base_ram_wdata(l4_base_wdata), .base_ram_rdata(base_rd),
        .ext_ram_en(l4_ext_en), .ext_ram_we(l4_ext_we), .ext_ram_addr(l4_ext_addr),
        .ext_ram_wdata(l4_ext_wdata), .ext_ram_rdata(ext_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running required=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        inst_en = 1'b0; inst_we = 4'h0; inst_addr = 32'h0; inst_wdata = 32'h0;
        data_en = 1'b0; data_we = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
        base_rd = 32'h0; ext_rd = 32'h0;
        tick();
        tick();
        check("rst_base_en", {31'h0, base_en}, 32'h0);
        check("rst_ext_en", {31'h0, ext_en}, 32'h0);
        check("rst_ram_we_addr", {8'h0, base_we, ext_we, base_addr[15:0]}, 32'h0);
        check("rst_inst_rdata", inst_rdata, 32'h0);
        check("rst_data_rdata", data_rdata, 32'h0);
        check("rst_done", {30'h0, if_done, mem_done}, 32'h0);
        reset = 1'b0;

        // Single base read from the instruction port.
        base_rd = 32'h1234_5678;
        inst_en = 1'b1; inst_addr = 32'h8000_0010;
        tick();
        check("rd_c1_base_en", {31'h0, base_en}, 32'h1);
        check("rd_c1_base_addr", {12'h0, base_addr}, 32'h4);
        check("rd_c1_ext_en", {31'h0, ext_en}, 32'h0);
        tick();
        check("rd_c2_base_en", {31'h0, base_en}, 32'h1);
        check("rd_c2_if_done", {31'h0, if_done}, 32'h0);
        tick();
        check("rd_c3_base_en", {31'h0, base_en}, 32'h0);
        check("rd_c3_if_done", {31'h0, if_done}, 32'h1);
        check("rd_c3_mem_done", {31'h0, mem_done}, 32'h0);
        check("rd_c3_rdata", inst_rdata, 32'h1234_5678);
        inst_en = 1'b0;
        tick();
        check("rd_c4_if_done", {31'h0, if_done}, 32'h0);
        check("rd_c4_rdata_hold", inst_rdata, 32'h1234_5678);

        // Data read from ext RAM, gives data_rdata a known non-zero value.
        ext_rd = 32'hCAFE_F00D;
        data_en = 1'b1; data_addr = 32'h8040_0004; data_we = 4'h0;
        tick();
        check("xrd_c1_ext_en", {31'h0, ext_en}, 32'h1);
        check("xrd_c1_ext_addr", {12'h0, ext_addr}, 32'h1);
        check("xrd_c1_base_en", {31'h0, base_en}, 32'h0);
        tick();
        tick();
        check("xrd_c3_mem_done", {31'h0, mem_done}, 32'h1);
        check("xrd_c3_if_done", {31'h0, if_done}, 32'h0);
        check("xrd_c3_rdata", data_rdata, 32'hCAFE_F00D);
        data_en = 1'b0;
        tick();

        // Ext byte write.
        data_en = 1'b1; data_addr = 32'h8040_0008; data_we = 4'b0010; data_wdata = 32'hAABB_CCDD;
        tick();
        check("wr_c1_ext_en", {31'h0, ext_en}, 32'h1);
        check("wr_c1_ext_we", {28'h0, ext_we}, 32'h2);
        check("wr_c1_ext_addr", {12'h0, ext_addr}, 32'h2);
        check("wr_c1_ext_wdata", ext_wdata, 32'hAABB_CCDD);
        check("wr_c1_base_en", {31'h0, base_en}, 32'h0);
        tick();
        check("wr_c2_ext_en", {31'h0, ext_en}, 32'h1);
        check("wr_c2_base_en", {31'h0, base_en}, 32'h0);
        tick();
        check("wr_c3_mem_done", {31'h0, mem_done}, 32'h1);
        check("wr_c3_ext_en", {31'h0, ext_en}, 32'h0);
        check("wr_c3_base_en", {31'h0, base_en}, 32'h0);
        check("wr_c3_data_rdata", data_rdata, 32'hCAFE_F00D);
        check("wr_c3_inst_rdata", inst_rdata, 32'h1234_5678);
        data_en = 1'b0; data_we = 4'h0;
        tick();

        // Unmapped read returns zero with no RAM enabled.
        base_rd = 32'h5555_5555; ext_rd = 32'h6666_6666;
        data_en = 1'b1; data_addr = 32'h1FC0_0000;
        for (int c = 1; c <= 2; c++) begin
            tick();
            check("um_base_en", {31'h0, base_en}, 32'h0);
            check("um_ext_en", {31'h0, ext_en}, 32'h0);
            check("um_mem_done", {31'h0, mem_done}, 32'h0);
        end
        tick();
        check("um_c3_mem_done", {31'h0, mem_done}, 32'h1);
        check("um_c3_rdata", data_rdata, 32'h0);
        data_en = 1'b0;
        tick();

        // Contention from reset: data, inst, data, inst.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_rd = 32'h1111_1111; ext_rd = 32'h2222_2222;
        inst_en = 1'b1; inst_addr = 32'h8000_0000;
        data_en = 1'b1; data_addr = 32'h8040_0000;
        for (int c = 1; c <= 16; c++) begin
            tick();
            check("ct_ext_en", {31'h0, ext_en},
                  {31'h0, (c == 1 || c == 2 || c == 9 || c == 10)});
            check("ct_base_en", {31'h0, base_en},
                  {31'h0, (c == 5 || c == 6 || c == 13 || c == 14)});
            check("ct_mem_done", {31'h0, mem_done}, {31'h0, (c == 3 || c == 11)});
            check("ct_if_done", {31'h0, if_done}, {31'h0, (c == 7 || c == 15)});
            check("ct_no_overlap", {31'h0, if_done & mem_done}, 32'h0);
            if (c == 3) check("ct_data_rdata", data_rdata, 32'h2222_2222);
            if (c == 7) check("ct_inst_rdata", inst_rdata, 32'h1111_1111);
        end
        inst_en = 1'b0; data_en = 1'b0;
        tick();

        // Reset asserted in the second ACCESS cycle.
        base_rd = 32'h1234_5678;
        inst_en = 1'b1; inst_addr = 32'h8000_0010;
        tick();
        check("rm_c1_base_en", {31'h0, base_en}, 32'h1);
        tick();
        check("rm_c2_base_en", {31'h0, base_en}, 32'h1);
        reset = 1'b1;
        #1;
        check("rm_async_base_en", {31'h0, base_en}, 32'h0);
        check("rm_async_base_addr", {12'h0, base_addr}, 32'h0);
        tick();
        check("rm_no_done_a", {30'h0, if_done, mem_done}, 32'h0);
        tick();
        check("rm_no_done_b", {30'h0, if_done, mem_done}, 32'h0);
        inst_en = 1'b0;
        reset = 1'b0;
        tick();
        check("rm_idle_done", {30'h0, if_done, mem_done}, 32'h0);
        base_rd = 32'h5A5A_5A5A;
        data_en = 1'b1; data_addr = 32'h8000_0020;
        tick();
        check("rm_fresh_base_en", {31'h0, base_en}, 32'h1);
        check("rm_fresh_addr", {12'h0, base_addr}, 32'h8);
        tick();
        tick();
        check("rm_fresh_mem_done", {31'h0, mem_done}, 32'h1);
        check("rm_fresh_if_done", {31'h0, if_done}, 32'h0);
        check("rm_fresh_rdata", data_rdata, 32'h5A5A_5A5A);
        data_en = 1'b0;
        tick();

        // Latency sweep on the RAM_LAT=1 and RAM_LAT=4 instances.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        base_rd = 32'h0BAD_BEEF;
        inst_en = 1'b1; inst_addr = 32'h8000_0008;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c <= 3) begin
                check("l1_base_en", {31'h0, l1_base_en}, {31'h0, (c == 1)});
                check("l1_if_done", {31'h0, l1_if_done}, {31'h0, (c == 2)});
            end
            if (c == 2) check("l1_rdata", l1_inst_rdata, 32'h0BAD_BEEF);
            check("l4_base_en", {31'h0, l4_base_en}, {31'h0, (c <= 4)});
            check("l4_if_done", {31'h0, l4_if_done}, {31'h0, (c == 5)});
            if (c == 1) check("l4_base_addr", {12'h0, l4_base_addr}, 32'h2);
            if (c == 5) begin
                check("l4_rdata", l4_inst_rdata, 32'h0BAD_BEEF);
                inst_en = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Single-master memory responder that serves both CPU SRAM-style request ports, instruction fetch and data access, from two external single-port RAMs (base RAM and ext RAM). It arbitrates between the ports and decodes the address to pick a RAM. It runs a multi-cycle access FSM and reports completion back to the pipeline through `is_if_read` / `is_mem_read`. It sits between `mycpu_top` and the board RAM pins.

## Interface
- `RAM_LAT`, 2: cycles the RAM enable is held per access (legal range 1..4).
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high reset.
- `inst_sram_en` in 1: instruction request.
- `inst_sram_we` in 4: byte write strobes.
- `inst_sram_addr` in 32: byte address.
- `inst_sram_wdata` in 32: write data.
- `inst_sram_rdata` out 32: read data, registered.
- `is_if_read` out 1: 1-cycle pulse when the instruction access completes.
- `data_sram_en`, `data_sram_we`, `data_sram_addr`, `data_sram_wdata`, `data_sram_rdata`: same as the inst port, for data accesses.
- `is_mem_read` out 1: 1-cycle pulse when the data access completes.
- `base_ram_en` out 1, `base_ram_we` out 4, `base_ram_addr` out 20 (word address), `base_ram_wdata` out 32, `base_ram_rdata` in 32: base RAM.
- `ext_ram_en`, `ext_ram_we`, `ext_ram_addr`, `ext_ram_wdata`, `ext_ram_rdata`: same as base RAM.

## Operation
- **Address decode:**
  - `addr[31:22]==10'h200` (0x8000_0000–0x803F_FFFF): base RAM.
  - `addr[31:22]==10'h201` (0x8040_0000–0x807F_FFFF): ext RAM.
  - Anything else: unmapped.
  - RAM word address = `addr[21:2]`.
- **Requester rule:** hold en/we/addr/wdata stable from assertion until the port's done pulse. The arbiter latches the fields at grant regardless.
- **FSM states:** IDLE, ACCESS, DONE.
- **IDLE:**
  - If any `*_sram_en` is high, grant and go to ACCESS.
  - On grant, latch port id, target, word address, we and wdata.
- **Arbitration:**
  - Single pending request: grant it.
  - Both pending: round-robin. Grant the port not granted last; after reset, data wins first.
- **ACCESS:**
  - Selected RAM en=1 with latched addr/we/wdata for exactly `RAM_LAT` cycles. The other RAM en=0.
  - A down-counter counts the cycles.
  - On the final cycle, a read (we==0) captures the selected `*_ram_rdata`.
  - Then go to DONE.
- **Unmapped access:** no RAM enable. Still spends `RAM_LAT` cycles in ACCESS. A read returns 32'h0; a write is dropped.
- **DONE:**
  - Pulse the granted port's done signal for one cycle.
  - Reads: the port's rdata register updates on entry to DONE and holds until that port's next read completes.
  - Writes: rdata is not updated.
  - Return to IDLE.
- Partial writes pass the strobes through unchanged. Reads ignore the strobes and return the full word.

## Timing
- **Reset values:**
  - All RAM en/we/addr/wdata = 0.
  - `inst_sram_rdata` = `data_sram_rdata` = 0.
  - `is_if_read` = `is_mem_read` = 0.
  - FSM = IDLE, last-grant = inst (so data wins first).
- **Latency:**
  - Request sampled in IDLE at edge 0.
  - RAM en high in cycles 1..`RAM_LAT`.
  - Done pulse and rdata valid in cycle `RAM_LAT`+1.
  - Next grant earliest at the edge ending cycle `RAM_LAT`+2.
  - Throughput: one access per `RAM_LAT`+2 cycles.
- RAM outputs are registered from FSM state; no combinational path from `*_sram_*` to `*_ram_*`.
- `*_ram_rdata` is sampled at the rising edge ending the last ACCESS cycle. The RAM must present data within `RAM_LAT` cycles of en.
- Requests arriving during ACCESS/DONE wait. No queueing beyond one pending request per port, held by the requester.
- **Reset mid-access:** asynchronous. RAM en drops immediately; no done pulse is issued; the interrupted write may be partial.
- Done pulses are never high for both ports in the same cycle.

## Test plan
- **Single base read:** `RAM_LAT`=2; inst read 0x8000_0010, base RAM returns 0x1234_5678 → `base_ram_addr`=20'h4 with en high 2 cycles, then `is_if_read` 1-cycle pulse with `inst_sram_rdata`=0x1234_5678 in cycle 3.
- **Ext byte write:** data write 0x8040_0008, we=4'b0010, wdata=0xAABB_CCDD → `ext_ram_en`=1, `ext_ram_we`=4'b0010, addr=20'h2, `base_ram_en`=0 throughout; `is_mem_read` pulses; `data_sram_rdata` unchanged.
- **Contention:** both ports request continuously from reset → grant order data, inst, data, inst; done pulses alternate every `RAM_LAT`+2 cycles and never coincide.
- **Unmapped read:** data read 0x1FC0_0000 → neither RAM enabled; after `RAM_LAT`+1 cycles `is_mem_read` pulses with `data_sram_rdata`=0.
- **Reset mid-access:** assert reset in the 2nd ACCESS cycle → RAM en=0 in the same cycle without waiting for the clock; no done pulse; after release a fresh request completes normally.
- **Latency sweep:** `RAM_LAT`=1 and 4 → en held exactly 1 and 4 cycles; done at cycle 2 and 5 respectively.
